// File: rtl/fifo_push_arb.sv
`default_nettype none
// fifo_push_arb: round-robin push arbiter and occupancy counter in front of the shared fifo.
// Optional macro FIFO_ARB_LOCK_EN adds a per-requester lock input that keeps the grant on one producer.
module fifo_push_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 36,
  parameter int DEPTH = 1024,
  parameter int ADDR  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
`ifdef FIFO_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       lock,
`endif
  output logic [N_REQ-1:0]       gnt,
  input  logic                   cons_pop,
  output logic                   pop_ok,
  output logic                   fifo_push,
  output logic                   fifo_pop,
  output logic [WIDTH-1:0]       fifo_din,
  output logic [ADDR:0]          count,
  output logic                   full
);

  localparam int             PW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR:0]  FULL_CNT = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0]  CNT_ONE  = (ADDR+1)'(1);
  localparam logic [PW-1:0]  PTR_RST  = PW'(N_REQ-1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;
  logic          hold;
  logic          grant_ok;

`ifdef FIFO_ARB_LOCK_EN
  logic          lock_vld;
  logic [PW-1:0] lock_own;
`endif

  assign full = (count == FULL_CNT);

  // A held lock pre-empts the round-robin search; otherwise scan from ptr+1.
  always_comb begin
    hold  = 1'b0;
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
`ifdef FIFO_ARB_LOCK_EN
    hold  = lock_vld && req[lock_own] && lock[lock_own];
`endif
    if (hold) begin
`ifdef FIFO_ARB_LOCK_EN
      win   = lock_own;
`endif
      found = 1'b1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = PW'((int'(ptr) + k) % N_REQ);
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  // Full withholds the grant even if a pop happens this cycle: no pop-to-grant path.
  assign grant_ok  = found && !full && !rst;
  assign gnt       = grant_ok ? (N_REQ'(1) << win) : '0;
  assign fifo_push = grant_ok;
  assign pop_ok    = cons_pop && (count != '0) && !rst;
  assign fifo_pop  = pop_ok;

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) fifo_din = fifo_din | req_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= PTR_RST;
      count <= '0;
    end else begin
      if (grant_ok) ptr <= win;
      case ({grant_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ARB_LOCK_EN
  // Stall under full keeps the lock as long as the owner still asserts req and lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld <= 1'b0;
      lock_own <= '0;
    end else if (grant_ok && lock[win]) begin
      lock_vld <= 1'b1;
      lock_own <= win;
    end else if (!hold) begin
      lock_vld <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/fifo_push_arb.md
# fifo_push_arb

Round-robin push-side arbiter and occupancy tracker for the shared `fifo` buffer in the return-address test datapath. It shares the single FIFO write port between N_REQ producers, granting at most one push per cycle. It keeps the occupancy count that the FIFO itself does not provide, and uses it to backpressure producers when full and to gate consumer pops when empty. It sits directly in front of `fifo`, driving its push/pop/din and observing nothing else.

## Interface
- N_REQ, 4, number of producers (2..8)
- WIDTH, 36, data width; must match fifo WIDTH
- DEPTH, 1024, FIFO depth; must match fifo DEPTH
- ADDR, 10, log2(DEPTH); count is ADDR+1 bits
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_REQ  per-producer push request; data valid while high
- req_data  in  N_REQ*WIDTH  producer data, slice i = bits [i*WIDTH +: WIDTH]
- gnt  out  N_REQ  one-hot grant; push accepted in the cycle gnt[i] is high
- cons_pop  in  1  consumer pop request
- pop_ok  out  1  cons_pop accepted this cycle
- fifo_push  out  1  to fifo push
- fifo_pop  out  1  to fifo pop
- fifo_din  out  WIDTH  to fifo din
- count  out  ADDR+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH

## Operation
- Grant is combinational from req, rr pointer, count and (if enabled) lock state; no grant when full is high.
- Round-robin: search starts at index ptr+1 mod N_REQ, first asserted req wins; on a grant, ptr <= granted index at next edge; no grant leaves ptr unchanged.
- fifo_push = |gnt; fifo_din = req_data slice of granted index, else all zeros.
- pop_ok = fifo_pop = cons_pop && (count != 0).
- Counter: push only -> count+1; pop only -> count-1; both or neither -> unchanged. Never exceeds DEPTH, never wraps below 0.
- Push and pop in the same cycle are legal at any count from 1 to DEPTH-1. At count 0 only push is possible. At DEPTH only pop is possible: the grant is withheld even if a pop occurs that cycle, so there is no pop-to-grant path.
- full is a function of registered count only.

## Timing
- Reset values: ptr = N_REQ-1, so index 0 wins first; count = 0; full = 0; lock state cleared. gnt, fifo_push, fifo_pop and pop_ok are 0 while rst is high, regardless of req and cons_pop.
- Push latency: request to grant/fifo_push is 0 cycles, same cycle. The data is in the FIFO at the next edge.
- count/full reflect an accepted push or pop one cycle after acceptance.
- Reset mid-operation: all state returns to reset values at that edge. The fifo is reset by the same rst, so count stays coherent.
- A producer must hold req and data stable until it sees gnt; dropping req without a grant is allowed and has no effect.

## Configuration
- Macro FIFO_ARB_LOCK_EN.
- Defined:
  - Adds input `lock` [N_REQ].
  - If requester i is granted with lock[i]=1, a lock owner register holds i. While req[i] && lock[i] remains high, i keeps the grant every non-full cycle, ignoring round-robin.
  - Lock releases in the first cycle req[i] or lock[i] is low; normal arbitration resumes in that same cycle.
  - full stalls the owner without releasing the lock.
  - ptr still updates to the owner index.
- Undefined: no lock port, pure round-robin.

## Test plan
- Reset, then req=4'b1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,…; count=8.
- Fill: req[2]=1 only, no pops, for DEPTH+3 cycles -> exactly DEPTH grants, full=1, count=1024, gnt=0 afterwards; then cons_pop 1 cycle -> count=1023, gnt resumes the cycle after.
- Empty pop: count=0, cons_pop=1 -> pop_ok=0, fifo_pop=0, count stays 0.
- Simultaneous: count=5, push and pop in the same cycle -> count stays 5; FIFO order is preserved, checked against a scoreboard.
- rst asserted after 10 pushes while req=1111 -> next cycle count=0, full=0, first grant goes to index 0.
- FIFO_ARB_LOCK_EN: req=1111, lock[1]=1 for 4 cycles -> gnt=0010 four times. Drop lock[1] -> next grant 0100.
